// File: rtl/shift_arb_pkg.sv
// Shared widths, FSM state encoding and latched-request layout for shift_arbiter.
package shift_arb_pkg;
  localparam int DATA_W  = 16;
  localparam int SHAMT_W = 4;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} arb_state_t;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHAMT_W-1:0] shamt;
    logic               mode;
  } shift_req_t;
endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between the ALU-issue side (master) and shift_arbiter (slave).
interface shift_arbiter_if
  import shift_arb_pkg::*;
#(
  parameter int NUM_REQ = shift_arb_pkg::NUM_REQ
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]              Req_Valid;
  logic [NUM_REQ-1:0]              Req_Ready;
  logic [NUM_REQ-1:0][DATA_W-1:0]  Req_In;
  logic [NUM_REQ-1:0][SHAMT_W-1:0] Req_Val;
  logic [NUM_REQ-1:0]              Req_Mode;
  logic                            Rsp_Valid;
  logic                            Rsp_Ready;
  logic [DATA_W-1:0]               Rsp_Data;
  logic [ID_W-1:0]                 Rsp_Id;

  modport master (
    output Req_Valid, Req_In, Req_Val, Req_Mode, Rsp_Ready,
    input  Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Id
  );

  modport slave (
    input  Req_Valid, Req_In, Req_Val, Req_Mode, Rsp_Ready,
    output Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Id
  );
endinterface

// File: rtl/shift_arbiter_shifter.sv
// Combinational barrel shifter: Mode 0 logical left, Mode 1 arithmetic right.
module shift_arbiter_shifter
  import shift_arb_pkg::*;
(
  input  logic [DATA_W-1:0]  Shift_In,
  input  logic [SHAMT_W-1:0] Shift_Val,
  input  logic               Mode,
  output logic [DATA_W-1:0]  Shift_Out
);
  // Keep the signed shift in its own signed net so the unsigned mux can't demote it to logical.
  logic signed [DATA_W-1:0] sin;
  logic signed [DATA_W-1:0] asr;

  assign sin       = Shift_In;
  assign asr       = sin >>> Shift_Val;
  assign Shift_Out = Mode ? asr : (Shift_In << Shift_Val);
endmodule

// File: rtl/shift_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared shifter, returns result + requester id.
// Define SHIFT_ARB_RR_EN for round-robin; otherwise fixed priority (lowest index wins).
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int NUM_REQ = shift_arb_pkg::NUM_REQ
)(
  input  logic           clk,
  input  logic           rst,
  shift_arbiter_if.slave bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t        state;
  shift_req_t        lat;
  logic [ID_W-1:0]   lat_id;
  logic [ID_W-1:0]   grant_id;
  logic              grant_any;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [ID_W-1:0]   rsp_id;
  logic [DATA_W-1:0] shift_out;

  assign grant_any = |bus.Req_Valid;

`ifdef SHIFT_ARB_RR_EN
  logic [ID_W-1:0] ptr;

  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s -= NUM_REQ;
    return ID_W'(s);
  endfunction

  // Scan downward so the closest valid index to ptr is the last (winning) assignment.
  always_comb begin
    grant_id = '0;
    for (int k = NUM_REQ-1; k >= 0; k--)
      if (bus.Req_Valid[rr_idx(ptr, k)]) grant_id = rr_idx(ptr, k);
  end

  always_ff @(posedge clk) begin
    if (rst)                              ptr <= '0;
    else if (state == IDLE && grant_any)  ptr <= rr_idx(grant_id, 1);
  end
`else
  always_comb begin
    grant_id = '0;
    for (int k = NUM_REQ-1; k >= 0; k--)
      if (bus.Req_Valid[k]) grant_id = ID_W'(k);
  end
`endif

  always_comb begin
    bus.Req_Ready = '0;
    if (state == IDLE && grant_any && !rst) bus.Req_Ready[grant_id] = 1'b1;
  end

  shift_arbiter_shifter u_shifter (
    .Shift_In  (lat.data),
    .Shift_Val (lat.shamt),
    .Mode      (lat.mode),
    .Shift_Out (shift_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat       <= '0;
      lat_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          lat.data  <= bus.Req_In[grant_id];
          lat.shamt <= bus.Req_Val[grant_id];
          lat.mode  <= bus.Req_Mode[grant_id];
          lat_id    <= grant_id;
          state     <= SHIFT;
        end
        SHIFT: begin
          rsp_data  <= shift_out;
          rsp_id    <= lat_id;
          rsp_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (bus.Rsp_Ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Rsp_Valid = rsp_valid;
  assign bus.Rsp_Data  = rsp_data;
  assign bus.Rsp_Id    = rsp_id;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter; expectations follow SHIFT_ARB_RR_EN when defined.
module tb_shift_arbiter;
  import shift_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_arbiter_if bus ();

  shift_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.Req_Ready == '0 && n < 8) begin
      step();
      n++;
    end
    if (bus.Req_Ready == '0) chk("rdy_timeout", 32'd0, 32'd1);
  endtask

  // One isolated request: ready -> accept edge -> SHIFT -> HOLD (checked) -> IDLE.
  task automatic do_op(input int id, input logic [15:0] din, input logic [3:0] val,
                       input logic mode, input logic [15:0] exp, input string tag);
    bus.Req_In[id]    = din;
    bus.Req_Val[id]   = val;
    bus.Req_Mode[id]  = mode;
    bus.Req_Valid     = '0;
    bus.Req_Valid[id] = 1'b1;
    bus.Rsp_Ready     = 1'b1;
    #1;
    wait_ready();
    chk({tag, "_rdy"}, 32'(bus.Req_Ready), 32'(1 << id));
    step();
    bus.Req_Valid = '0;
    #1;
    chk({tag, "_shift_vld"}, 32'(bus.Rsp_Valid), 32'd0);
    step();
    chk({tag, "_vld"},  32'(bus.Rsp_Valid), 32'd1);
    chk({tag, "_data"}, 32'(bus.Rsp_Data),  32'(exp));
    chk({tag, "_id"},   32'(bus.Rsp_Id),    32'(id));
    step();
    chk({tag, "_done"}, 32'(bus.Rsp_Valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_id;
    bus.Req_Valid = 2'b11;
    bus.Req_In    = '0;
    bus.Req_Val   = '0;
    bus.Req_Mode  = '0;
    bus.Rsp_Ready = 1'b0;
    rst = 1'b1;

    // Reset with both requesters pending
    step();
    chk("rst1_vld", 32'(bus.Rsp_Valid), 32'd0);
    chk("rst1_rdy", 32'(bus.Req_Ready), 32'd0);
    step();
    chk("rst2_vld",  32'(bus.Rsp_Valid), 32'd0);
    chk("rst2_rdy",  32'(bus.Req_Ready), 32'd0);
    chk("rst2_data", 32'(bus.Rsp_Data),  32'd0);
    chk("rst2_id",   32'(bus.Rsp_Id),    32'd0);
    rst = 1'b0;
    #1;
    chk("first_grant", 32'(bus.Req_Ready), 32'd1);

    // Single-requester arithmetic
    do_op(0, 16'h8001, 4'd4,  1'b1, 16'hF800, "asr4");
    do_op(1, 16'h00FF, 4'd8,  1'b0, 16'hFF00, "lsl8");
    do_op(1, 16'h8000, 4'd15, 1'b1, 16'hFFFF, "asr15");
    do_op(1, 16'h1234, 4'd0,  1'b0, 16'h1234, "lsl0");
    do_op(0, 16'h8421, 4'd0,  1'b1, 16'h8421, "asr0");
    do_op(0, 16'hF00F, 4'd4,  1'b0, 16'h00F0, "lsl_trunc");
    do_op(1, 16'h7FFF, 4'd3,  1'b1, 16'h0FFF, "asr_pos");

    // Both requesters continuously valid; last grant above was req1
    bus.Req_In[0] = 16'h0001; bus.Req_Val[0] = 4'd1; bus.Req_Mode[0] = 1'b0;
    bus.Req_In[1] = 16'h0003; bus.Req_Val[1] = 4'd2; bus.Req_Mode[1] = 1'b0;
    bus.Req_Valid = 2'b11;
    bus.Rsp_Ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
`ifdef SHIFT_ARB_RR_EN
      exp_id = i % 2;
`else
      exp_id = 0;
`endif
      wait_ready();
      chk($sformatf("arb%0d_rdy", i), 32'(bus.Req_Ready), (exp_id == 1) ? 32'd2 : 32'd1);
      step();
      step();
      chk($sformatf("arb%0d_id", i),   32'(bus.Rsp_Id),   32'(exp_id));
      chk($sformatf("arb%0d_data", i), 32'(bus.Rsp_Data), (exp_id == 1) ? 32'h000C : 32'h0002);
      step();
    end

    // Back-pressure in HOLD while new requests arrive
    bus.Req_Valid = 2'b10;
    bus.Req_In[1] = 16'h0F00; bus.Req_Val[1] = 4'd2; bus.Req_Mode[1] = 1'b0;
    bus.Rsp_Ready = 1'b0;
    #1;
    wait_ready();
    chk("bp_rdy", 32'(bus.Req_Ready), 32'd2);
    step();
    bus.Req_Valid = 2'b11;
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d_vld", i),  32'(bus.Rsp_Valid), 32'd1);
      chk($sformatf("hold%0d_data", i), 32'(bus.Rsp_Data),  32'h3C00);
      chk($sformatf("hold%0d_id", i),   32'(bus.Rsp_Id),    32'd1);
      chk($sformatf("hold%0d_rdy", i),  32'(bus.Req_Ready), 32'd0);
      step();
    end
    bus.Rsp_Ready = 1'b1;
    #1;
    chk("release_rdy", 32'(bus.Req_Ready), 32'd0);
    step();
    chk("idle_vld", 32'(bus.Rsp_Valid), 32'd0);
    chk("idle_rdy", 32'(bus.Req_Ready), 32'd1);
    step();
    chk("regrant_shift_rdy", 32'(bus.Req_Ready), 32'd0);
    bus.Req_Valid = '0;
    step();
    chk("regrant_data", 32'(bus.Rsp_Data), 32'h0002);
    chk("regrant_id",   32'(bus.Rsp_Id),   32'd0);
    step();

    // Reset while in SHIFT aborts the operation and clears the pointer
    bus.Req_Valid = 2'b01;
    bus.Req_In[0] = 16'hABCD; bus.Req_Val[0] = 4'd4; bus.Req_Mode[0] = 1'b0;
    #1;
    wait_ready();
    step();
    bus.Req_Valid = '0;
    rst = 1'b1;
    step();
    chk("abort_vld", 32'(bus.Rsp_Valid), 32'd0);
    chk("abort_rdy", 32'(bus.Req_Ready), 32'd0);
    rst = 1'b0;
    bus.Req_In[1] = 16'h4000; bus.Req_Val[1] = 4'd14; bus.Req_Mode[1] = 1'b1;
    bus.Req_Valid = 2'b11;
    #1;
    chk("abort_ptr",  32'(bus.Req_Ready), 32'd1);
    chk("abort_data", 32'(bus.Rsp_Data),  32'd0);
    step();
    chk("abort_novld", 32'(bus.Rsp_Valid), 32'd0);
    step();
    chk("abort_norsp", 32'(bus.Rsp_Valid), 32'd1);
    chk("post_rst_data", 32'(bus.Rsp_Data), 32'hBCD0);
    bus.Req_Valid = '0;
    step();
    do_op(1, 16'h4000, 4'd14, 1'b1, 16'h0001, "asr14");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
